// File: rtl/vx_commit_pkg.sv
// vx_commit_pkg: shared bundle layout, FSM states and arbiter source indices for the commit stage
package vx_commit_pkg;
  localparam int CMT_DATAW = 128;
  localparam int UUID_W = 44;
  localparam int UUID_LSB = CMT_DATAW - UUID_W;
  localparam int WB_BIT = 38;
  localparam int EOP_BIT = 0;
`ifdef VX_COMMIT_FPU_EN
  localparam int NUM_SRC = 4;
`else
  localparam int NUM_SRC = 3;
`endif
  typedef enum logic [0:0] {IDLE, DRAIN} commit_state_t;
  typedef enum logic [1:0] {SRC_ALU, SRC_LSU, SRC_SFU, SRC_FPU} src_t;
  function automatic logic [UUID_W-1:0] uuid_of(input logic [CMT_DATAW-1:0] b);
    return b[CMT_DATAW-1 -: UUID_W];
  endfunction
endpackage

// File: rtl/vx_commit_slot.sv
// vx_commit_slot: one issue slot -- round-robin result arbiter, writeback register and mispredict drain FSM
module vx_commit_slot
  import vx_commit_pkg::*;
#(
  parameter int DRAIN_CYCLES = 8
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [NUM_SRC-1:0]                src_valid,
  input  logic [NUM_SRC-1:0][CMT_DATAW-1:0] src_data,
  input  logic                              mispredict,
  output logic [NUM_SRC-1:0]                src_ready,
  output logic                              wb_valid,
  output logic [CMT_DATAW-1:0]              wb_data,
  output logic                              commit_if_valid,
  output logic                              commit_if_ready,
  output logic                              flush
);
  localparam int CW = $clog2(DRAIN_CYCLES + 1);
  commit_state_t     state;
  logic [1:0]        ptr, win;
  logic              any, squash, take, mp;
  logic [CW-1:0]     cnt;
  logic [UUID_W-1:0] flush_uuid, uuid;
  logic [CMT_DATAW-1:0] sel;
  // first valid source at or after the round-robin pointer wins; ready is the grant itself
  always_comb begin
    win = ptr;
    any = 1'b0;
    for (int k = NUM_SRC - 1; k >= 0; k--)
      if (src_valid[(int'(ptr) + k) % NUM_SRC]) begin
        win = 2'((int'(ptr) + k) % NUM_SRC);
        any = 1'b1;
      end
    src_ready = any ? NUM_SRC'(1) << win : '0;
  end
  assign sel    = src_data[win];
  assign uuid   = uuid_of(sel);
  assign squash = state == DRAIN && uuid > flush_uuid;
  assign take   = any && !squash;
  assign mp     = take && win == SRC_ALU && mispredict;
  // registered writeback/commit outputs, pointer rotation and the flush/drain FSM
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      ptr             <= '0;
      cnt             <= '0;
      flush_uuid      <= '0;
      wb_valid        <= 1'b0;
      wb_data         <= '0;
      commit_if_valid <= 1'b0;
      commit_if_ready <= 1'b0;
      flush           <= 1'b0;
    end else begin
      if (any) ptr <= (win == 2'(NUM_SRC - 1)) ? 2'd0 : win + 2'd1;
      if (take) wb_data <= sel;
      wb_valid        <= take && sel[WB_BIT];
      commit_if_valid <= take;
      commit_if_ready <= take && sel[EOP_BIT];
      flush           <= mp;
      if (mp) begin
        flush_uuid <= uuid;
        cnt        <= CW'(DRAIN_CYCLES);
        state      <= DRAIN;
      end else if (state == DRAIN) begin
        if (cnt == '0) state <= IDLE;
        else cnt <= cnt - CW'(1);
      end
    end
  end
endmodule

// File: rtl/vx_commit_scalar.sv
// vx_commit_scalar: per-slot commit/writeback stage; define VX_COMMIT_FPU_EN to add the FPU result port
module vx_commit_scalar
  import vx_commit_pkg::*;
#(
  parameter int ISSUE_CNT    = 4,
  parameter int DRAIN_CYCLES = 8
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [ISSUE_CNT-1:0]           alu_valid,
  input  logic [ISSUE_CNT*CMT_DATAW-1:0] alu_data,
  input  logic [ISSUE_CNT-1:0]           alu_mispredict,
  output logic [ISSUE_CNT-1:0]           alu_ready,
  input  logic [ISSUE_CNT-1:0]           lsu_valid,
  input  logic [ISSUE_CNT*CMT_DATAW-1:0] lsu_data,
  output logic [ISSUE_CNT-1:0]           lsu_ready,
  input  logic [ISSUE_CNT-1:0]           sfu_valid,
  input  logic [ISSUE_CNT*CMT_DATAW-1:0] sfu_data,
  output logic [ISSUE_CNT-1:0]           sfu_ready,
`ifdef VX_COMMIT_FPU_EN
  input  logic [ISSUE_CNT-1:0]           fpu_valid,
  input  logic [ISSUE_CNT*CMT_DATAW-1:0] fpu_data,
  output logic [ISSUE_CNT-1:0]           fpu_ready,
`endif
  output logic [ISSUE_CNT-1:0]           wb_valid,
  output logic [ISSUE_CNT*CMT_DATAW-1:0] wb_data,
  output logic [ISSUE_CNT-1:0]           commit_if_valid,
  output logic [ISSUE_CNT-1:0]           commit_if_ready,
  output logic [ISSUE_CNT-1:0]           branch_mispredict_flush
);
  for (genvar g = 0; g < ISSUE_CNT; g++) begin : g_slot
    logic [NUM_SRC-1:0]                v, r;
    logic [NUM_SRC-1:0][CMT_DATAW-1:0] d;
`ifdef VX_COMMIT_FPU_EN
    assign v = {fpu_valid[g], sfu_valid[g], lsu_valid[g], alu_valid[g]};
    assign d = {fpu_data[g*CMT_DATAW +: CMT_DATAW], sfu_data[g*CMT_DATAW +: CMT_DATAW],
                lsu_data[g*CMT_DATAW +: CMT_DATAW], alu_data[g*CMT_DATAW +: CMT_DATAW]};
    assign fpu_ready[g] = r[SRC_FPU];
`else
    assign v = {sfu_valid[g], lsu_valid[g], alu_valid[g]};
    assign d = {sfu_data[g*CMT_DATAW +: CMT_DATAW], lsu_data[g*CMT_DATAW +: CMT_DATAW],
                alu_data[g*CMT_DATAW +: CMT_DATAW]};
`endif
    assign alu_ready[g] = r[SRC_ALU];
    assign lsu_ready[g] = r[SRC_LSU];
    assign sfu_ready[g] = r[SRC_SFU];
    vx_commit_slot #(.DRAIN_CYCLES(DRAIN_CYCLES)) u_slot (
      .clk             (clk),
      .reset_n         (reset_n),
      .src_valid       (v),
      .src_data        (d),
      .mispredict      (alu_mispredict[g]),
      .src_ready       (r),
      .wb_valid        (wb_valid[g]),
      .wb_data         (wb_data[g*CMT_DATAW +: CMT_DATAW]),
      .commit_if_valid (commit_if_valid[g]),
      .commit_if_ready (commit_if_ready[g]),
      .flush           (branch_mispredict_flush[g])
    );
  end
endmodule

// File: tb/tb_vx_commit_scalar.sv
// tb_vx_commit_scalar: directed and random checks of arbitration, latency and mispredict drain against a reference model
module tb_vx_commit_scalar;
  localparam int N = 4;
  localparam int W = 128;
  localparam int DC = 8;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [N-1:0] alu_valid = '0, alu_mispredict = '0, lsu_valid = '0, sfu_valid = '0;
  logic [N*W-1:0] alu_data = '0, lsu_data = '0, sfu_data = '0;
  logic [N-1:0] alu_ready, lsu_ready, sfu_ready;
  logic [N-1:0] wb_valid, commit_if_valid, commit_if_ready, branch_mispredict_flush;
  logic [N*W-1:0] wb_data;
`ifdef VX_COMMIT_FPU_EN
  logic [N-1:0] fpu_valid = '0, fpu_ready;
  logic [N*W-1:0] fpu_data = '0;
`endif
  int checks = 0, errors = 0, cyc = 0;
  int ptr[N], fl_start[N];
  logic [43:0] fuuid[N];
  logic [W-1:0] ed[N];
  always #5 clk = ~clk;
  vx_commit_scalar #(.ISSUE_CNT(N), .DRAIN_CYCLES(DC)) dut (
    .clk(clk), .reset_n(reset_n),
    .alu_valid(alu_valid), .alu_data(alu_data), .alu_mispredict(alu_mispredict), .alu_ready(alu_ready),
    .lsu_valid(lsu_valid), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .sfu_valid(sfu_valid), .sfu_data(sfu_data), .sfu_ready(sfu_ready),
`ifdef VX_COMMIT_FPU_EN
    .fpu_valid(fpu_valid), .fpu_data(fpu_data), .fpu_ready(fpu_ready),
`endif
    .wb_valid(wb_valid), .wb_data(wb_data), .commit_if_valid(commit_if_valid),
    .commit_if_ready(commit_if_ready), .branch_mispredict_flush(branch_mispredict_flush)
  );
  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [W-1:0] mk(input int u, input bit wb, input bit eop);
    logic [W-1:0] b;
    b = {$urandom, $urandom, $urandom, $urandom};
    b[127:84] = 44'(u);
    b[38] = wb;
    b[0] = eop;
    return b;
  endfunction
  task automatic clr();
    alu_valid = '0; lsu_valid = '0; sfu_valid = '0; alu_mispredict = '0;
  endtask
  task automatic drv(input int src, input int s, input int u, input bit wb, input bit eop, input bit mp);
    if (src == 0) begin
      alu_valid[s] = 1'b1; alu_data[s*W +: W] = mk(u, wb, eop); alu_mispredict[s] = mp;
    end else if (src == 1) begin
      lsu_valid[s] = 1'b1; lsu_data[s*W +: W] = mk(u, wb, eop);
    end else begin
      sfu_valid[s] = 1'b1; sfu_data[s*W +: W] = mk(u, wb, eop);
    end
  endtask
  task automatic model_reset();
    for (int s = 0; s < N; s++) begin
      ptr[s] = 0; fl_start[s] = -100; fuuid[s] = '0; ed[s] = '0;
    end
  endtask
  task automatic step();
    logic [2:0] er[N];
    logic ev[N], ec[N], ecr[N], ef[N];
    @(negedge clk);
    for (int s = 0; s < N; s++) begin
      logic [2:0] v;
      logic [W-1:0] d[3];
      logic [43:0] u;
      int w;
      bit sq;
      v = {sfu_valid[s], lsu_valid[s], alu_valid[s]};
      d[0] = alu_data[s*W +: W]; d[1] = lsu_data[s*W +: W]; d[2] = sfu_data[s*W +: W];
      w = -1;
      for (int k = 0; k < 3; k++) if (w < 0 && v[(ptr[s] + k) % 3]) w = (ptr[s] + k) % 3;
      er[s] = (w < 0) ? 3'b000 : 3'(1 << w);
      chk($sformatf("ready slot%0d cyc%0d", s, cyc), W'({sfu_ready[s], lsu_ready[s], alu_ready[s]}), W'(er[s]));
      ev[s] = 0; ec[s] = 0; ecr[s] = 0; ef[s] = 0;
      if (w >= 0) begin
        u = d[w][127:84];
        sq = cyc >= fl_start[s] && cyc <= fl_start[s] + DC && u > fuuid[s];
        ec[s] = !sq;
        ev[s] = !sq && d[w][38];
        ecr[s] = !sq && d[w][0];
        ef[s] = !sq && w == 0 && alu_mispredict[s];
        if (ef[s]) begin fuuid[s] = u; fl_start[s] = cyc + 1; end
        if (!sq) ed[s] = d[w];
        ptr[s] = (w + 1) % 3;
      end
    end
    @(posedge clk); #1;
    for (int s = 0; s < N; s++) begin
      chk($sformatf("wb_valid slot%0d cyc%0d", s, cyc), W'(wb_valid[s]), W'(ev[s]));
      chk($sformatf("commit_valid slot%0d cyc%0d", s, cyc), W'(commit_if_valid[s]), W'(ec[s]));
      chk($sformatf("commit_ready slot%0d cyc%0d", s, cyc), W'(commit_if_ready[s]), W'(ecr[s]));
      chk($sformatf("flush slot%0d cyc%0d", s, cyc), W'(branch_mispredict_flush[s]), W'(ef[s]));
      chk($sformatf("wb_data slot%0d cyc%0d", s, cyc), wb_data[s*W +: W], ed[s]);
    end
    cyc++;
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, " wb_valid"}, W'(wb_valid), '0);
    chk({tag, " commit_valid"}, W'(commit_if_valid), '0);
    chk({tag, " commit_ready"}, W'(commit_if_ready), '0);
    chk({tag, " flush"}, W'(branch_mispredict_flush), '0);
    chk({tag, " wb_data"}, wb_data[W-1:0], '0);
  endtask
  initial begin
    model_reset();
    #2 chk_zero("reset");
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    drv(0, 0, 5, 1, 1, 0); step(); clr();
    drv(0, 2, 1, 1, 1, 0); drv(1, 2, 2, 1, 0, 0); drv(2, 2, 3, 0, 1, 0);
    repeat (6) step();
    clr();
    drv(0, 3, 10, 1, 1, 1); step(); clr();
    drv(1, 3, 12, 1, 1, 0); step(); clr();
    drv(1, 3, 9, 1, 1, 0); step(); clr();
    step();
    drv(0, 3, 7, 1, 0, 1); step(); clr();
    drv(1, 3, 8, 1, 1, 0); step(); clr();
    repeat (9) step();
    drv(1, 3, 12, 1, 1, 0); step(); clr();
    drv(0, 1, 30, 1, 1, 1); step(); clr();
    drv(1, 1, 25, 1, 1, 0); step();
    chk("wb_valid before reset", W'(wb_valid[1]), W'(1));
    #2 reset_n = 1'b0; clr();
    #1 chk_zero("mid-drain reset");
    model_reset();
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    drv(1, 1, 20, 1, 1, 0); step(); clr();
    drv(2, 0, 3, 0, 0, 0); step(); clr();
    for (int i = 0; i < 400; i++) begin
      clr();
      for (int s = 0; s < N; s++)
        for (int src = 0; src < 3; src++)
          if ($urandom_range(0, 1) == 1)
            drv(src, s, $urandom_range(0, 40), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                $urandom_range(0, 5) == 0);
      step();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
